// File: rtl/mem_bus_controller_pkg.sv
// Shared definitions for the CPU data-memory access controller:
// FSM state encoding, internal RAM window constants and an alignment helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INT_RD  = 2'd1,
    ST_EXT_REQ = 2'd2,
    ST_EXT_REL = 2'd3
  } state_t;

  // Internal RAM window in the CPU address map (offset is rebased by the decoder)
  localparam logic [31:0] INT_BASE = 32'h0000_1000;
  localparam logic [31:0] INT_SIZE = 32'h0000_0400;

  // Word accesses only: the two low address bits must be zero
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_controller_if.sv
// Bundle of CPU-side, internal-RAM and external-bus signals of the controller.
// slave  = the controller's view, master = the surrounding system's view.
interface mem_bus_controller_if #(parameter int INT_AW = 8);

  logic [31:0]       cpu_addr;
  logic              cpu_cs;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_done;
  logic              bus_err;
  logic [INT_AW-1:0] int_addr;
  logic              int_we;
  logic              int_re;
  logic [31:0]       int_wdata;
  logic [31:0]       int_rdata;
  logic [31:0]       ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_we;
  logic              ext_req;
  logic              ext_ack;
  logic [31:0]       ext_rdata;

  modport slave (
    input  cpu_addr, cpu_cs, cpu_rd, cpu_wr, cpu_wdata, int_rdata, ext_ack, ext_rdata,
    output cpu_rdata, cpu_stall, cpu_done, bus_err, int_addr, int_we, int_re, int_wdata,
           ext_addr, ext_wdata, ext_we, ext_req
  );

  modport master (
    output cpu_addr, cpu_cs, cpu_rd, cpu_wr, cpu_wdata, int_rdata, ext_ack, ext_rdata,
    input  cpu_rdata, cpu_stall, cpu_done, bus_err, int_addr, int_we, int_re, int_wdata,
           ext_addr, ext_wdata, ext_we, ext_req
  );

endinterface

// File: rtl/mem_bus_controller_ext_handshake.sv
// External 4-phase req/ack sequencer: owns the registered request line and the
// shared wait counter used for both the ack-rise and ack-fall timeouts.
module ext_handshake #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,   // access accepted in IDLE
  input  logic i_in_req,  // controller is in EXT_REQ
  input  logic i_in_rel,  // controller is in EXT_REL
  input  logic i_ack,
  output logic o_req,
  output logic o_tmo      // counter reached TIMEOUT-1 in the current wait
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          w_wait;
  logic          w_tmo;

  // Still waiting: for ack to rise while requesting, or to fall while releasing
  assign w_wait = (i_in_req & ~i_ack) | (i_in_rel & i_ack);
  assign w_tmo  = (r_cnt == LAST);
  assign o_tmo  = w_tmo;
  assign o_req  = r_req;

  // Counter restarts at each phase change; request held until ack or timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
      r_req <= 1'b0;
    end else begin
      if (w_wait && !w_tmo && !i_start) begin
        r_cnt <= r_cnt + ONE;
      end else begin
        r_cnt <= {CW{1'b0}};
      end
      r_req <= i_start | (i_in_req & ~i_ack & ~w_tmo);
    end
  end

endmodule

// File: rtl/mem_bus_controller.sv
// CPU data-memory access controller: zero-stall internal writes, one-stall
// internal reads, and external accesses over a req/ack handshake with timeout.
module mem_bus_controller #(
  parameter int TIMEOUT = 16,
  parameter int INT_AW  = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_bus_controller_if.slave bus
);

  import mem_bus_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ext_addr;
  logic [31:0] r_ext_wdata;
  logic [31:0] r_cpu_rdata;
  logic        r_ext_we;
  logic        r_err;

  logic w_start, w_cap, w_set_err;
  logic w_int_we, w_int_re, w_done, w_err, w_stall;
  logic w_ext_req, w_tmo;

  ext_handshake #(.TIMEOUT(TIMEOUT)) u_ext_handshake (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_in_req (r_state == ST_EXT_REQ),
    .i_in_rel (r_state == ST_EXT_REL),
    .i_ack    (bus.ext_ack),
    .o_req    (w_ext_req),
    .o_tmo    (w_tmo)
  );

  // Next state and per-cycle strobes; everything forced low while reset is held
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_cap     = 1'b0;
    w_set_err = 1'b0;
    w_int_we  = 1'b0;
    w_int_re  = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_stall   = 1'b0;
    if (i_rst) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_rd && bus.cpu_wr) begin
            w_err = 1'b1;
          end else if ((bus.cpu_rd || bus.cpu_wr) && !is_aligned(bus.cpu_addr)) begin
            w_err = 1'b1;
          end else if (bus.cpu_cs && bus.cpu_wr) begin
            w_int_we = 1'b1;
            w_done   = 1'b1;
          end else if (bus.cpu_cs && bus.cpu_rd) begin
            w_int_re = 1'b1;
            w_stall  = 1'b1;
            w_next   = ST_INT_RD;
          end else if (bus.cpu_rd || bus.cpu_wr) begin
            w_start = 1'b1;
            w_stall = 1'b1;
            w_next  = ST_EXT_REQ;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_INT_RD: begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
        ST_EXT_REQ: begin
          w_stall = 1'b1;
          if (bus.ext_ack) begin
            w_cap  = ~r_ext_we;
            w_next = ST_EXT_REL;
          end else if (w_tmo) begin
            w_err     = 1'b1;
            w_set_err = 1'b1;
            w_next    = ST_EXT_REL;
          end else begin
            w_next = ST_EXT_REQ;
          end
        end
        ST_EXT_REL: begin
          if (!bus.ext_ack) begin
            w_done = ~r_err;
            w_next = ST_IDLE;
          end else if (w_tmo) begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register, latched external access and read-data holding register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ext_addr  <= 32'h0;
      r_ext_wdata <= 32'h0;
      r_ext_we    <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_ext_addr  <= bus.cpu_addr;
        r_ext_wdata <= bus.cpu_wdata;
        r_ext_we    <= bus.cpu_wr;
        r_err       <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_INT_RD) begin
        r_cpu_rdata <= bus.int_rdata;
      end else if (w_cap) begin
        r_cpu_rdata <= bus.ext_rdata;
      end
    end
  end

  // RAM data is forwarded in the completion cycle, then held by the register
  assign bus.cpu_rdata = (r_state == ST_INT_RD) ? bus.int_rdata : r_cpu_rdata;
  assign bus.cpu_stall = w_stall;
  assign bus.cpu_done  = w_done;
  assign bus.bus_err   = w_err;
  assign bus.int_we    = w_int_we;
  assign bus.int_re    = w_int_re;
  assign bus.int_addr  = (w_int_we || w_int_re) ? bus.cpu_addr[INT_AW+1:2] : {INT_AW{1'b0}};
  assign bus.int_wdata = w_int_we ? bus.cpu_wdata : 32'h0;
  assign bus.ext_addr  = r_ext_addr;
  assign bus.ext_wdata = r_ext_wdata;
  assign bus.ext_we    = r_ext_we;
  assign bus.ext_req   = w_ext_req;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller: internal write/read, external read,
// external timeout, request errors and asynchronous reset mid-handshake.
module tb_mem_bus_controller;

  import mem_bus_pkg::*;

  localparam logic [31:0] LAST_OFF    = INT_SIZE - 32'd4;
  localparam logic [31:0] EXT_RD_ADDR = INT_BASE + 32'h0000_1000;
  localparam logic [31:0] EXT_WR_ADDR = INT_BASE + 32'h0000_2000;

  logic clk = 1'b0;
  logic rst;

  mem_bus_controller_if #(.INT_AW(8)) bus ();

  mem_bus_controller #(.TIMEOUT(16), .INT_AW(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Internal RAM model: one-cycle read latency, write on strobe
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[255]      <= 32'h1234_5678;
      bus.int_rdata <= 32'h0;
    end else begin
      if (bus.int_we) mem[bus.int_addr] <= bus.int_wdata;
      if (bus.int_re) bus.int_rdata <= mem[bus.int_addr];
    end
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  int n, reqc, errc, donec;
  logic err_with_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
    end else begin
      exp = 32'hxxxx_xxxx;
    end
    chk(tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_addr = 32'h0; bus.cpu_cs = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.cpu_wdata = 32'h0; bus.ext_ack = 1'b0; bus.ext_rdata = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.cpu_stall), 32'h0);
    chk("rst_done",  32'(bus.cpu_done),  32'h0);
    chk("rst_err",   32'(bus.bus_err),   32'h0);
    chk("rst_req",   32'(bus.ext_req),   32'h0);
    chk("rst_eaddr", bus.ext_addr,       32'h0);
    chk("rst_rdata", bus.cpu_rdata,      32'h0);
    @(negedge clk); rst = 1'b0;

    // internal write: zero-stall
    @(negedge clk);
    bus.cpu_cs = 1'b1; bus.cpu_addr = 32'h0000_0004; bus.cpu_wr = 1'b1; bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("iw_we",    32'(bus.int_we),    32'h1);
    chk("iw_addr",  32'(bus.int_addr),  32'h1);
    chk("iw_wdata", bus.int_wdata,      32'hDEAD_BEEF);
    chk("iw_done",  32'(bus.cpu_done),  32'h1);
    chk("iw_stall", 32'(bus.cpu_stall), 32'h0);
    @(negedge clk); bus.cpu_wr = 1'b0;
    #1;
    chk("iw_ram",   mem[1],             32'hDEAD_BEEF);
    chk("iw_idle",  32'(bus.cpu_stall), 32'h0);

    // internal read of the last word
    @(negedge clk);
    bus.cpu_addr = LAST_OFF; bus.cpu_rd = 1'b1; sb_q.push_back(32'h1234_5678);
    #1;
    chk("ir_re",    32'(bus.int_re),    32'h1);
    chk("ir_addr",  32'(bus.int_addr),  32'hFF);
    chk("ir_stall", 32'(bus.cpu_stall), 32'h1);
    chk("ir_done0", 32'(bus.cpu_done),  32'h0);
    @(negedge clk); #1;
    chk("ir_done",  32'(bus.cpu_done),  32'h1);
    chk("ir_stal2", 32'(bus.cpu_stall), 32'h0);
    chk_sb("ir_rdata", bus.cpu_rdata);
    bus.cpu_rd = 1'b0;
    @(negedge clk); #1;
    chk("ir_hold",  bus.cpu_rdata,      32'h1234_5678);

    // external read, ack 3 cycles after req
    @(negedge clk);
    bus.cpu_cs = 1'b0; bus.cpu_addr = EXT_RD_ADDR; bus.cpu_rd = 1'b1; sb_q.push_back(32'hCAFE_F00D);
    #1;
    chk("er_stall0", 32'(bus.cpu_stall), 32'h1);
    chk("er_req0",   32'(bus.ext_req),   32'h0);
    @(negedge clk); #1;
    chk("er_req",    32'(bus.ext_req),   32'h1);
    chk("er_addr",   bus.ext_addr,       32'h0000_2000);
    chk("er_we",     32'(bus.ext_we),    32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("er_req3",   32'(bus.ext_req),   32'h1);
    bus.ext_ack = 1'b1; bus.ext_rdata = 32'hCAFE_F00D;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (bus.ext_req && n < 20);
    chk("er_reqlat", 32'(n),             32'h1);
    chk("er_stall1", 32'(bus.cpu_stall), 32'h1);
    chk("er_done0",  32'(bus.cpu_done),  32'h0);
    bus.ext_ack = 1'b0; bus.ext_rdata = 32'h0;
    #1;
    chk("er_done",   32'(bus.cpu_done),  32'h1);
    chk("er_stall2", 32'(bus.cpu_stall), 32'h0);
    chk_sb("er_rdata", bus.cpu_rdata);
    bus.cpu_rd = 1'b0;
    @(negedge clk); #1;
    chk("er_hold",   bus.cpu_rdata,      32'hCAFE_F00D);

    // external write that never gets an ack
    @(negedge clk);
    bus.cpu_addr = EXT_WR_ADDR; bus.cpu_wr = 1'b1; bus.cpu_wdata = 32'h55AA_55AA;
    reqc = 0; errc = 0; donec = 0; err_with_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        chk("to_we",    32'(bus.ext_we), 32'h1);
        chk("to_wdata", bus.ext_wdata,   32'h55AA_55AA);
      end
      if (bus.ext_req) reqc++;
      if (bus.bus_err) begin errc++; err_with_req = bus.ext_req; end
      if (bus.cpu_done) donec++;
      if (!bus.cpu_stall) break;
    end
    chk("to_reqcnt",  32'(reqc),          32'd16);
    chk("to_errcnt",  32'(errc),          32'd1);
    chk("to_errlast", 32'(err_with_req),  32'h1);
    chk("to_nodone",  32'(donec),         32'd0);
    chk("to_exit",    32'(bus.cpu_stall), 32'h0);
    bus.cpu_wr = 1'b0;
    @(negedge clk); #1;
    chk("to_idle",    32'(bus.ext_req),   32'h0);

    // rd and wr together
    @(negedge clk);
    bus.cpu_cs = 1'b1; bus.cpu_addr = 32'h0000_0004; bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1;
    #1;
    chk("e1_err",   32'(bus.bus_err),   32'h1);
    chk("e1_we",    32'(bus.int_we),    32'h0);
    chk("e1_re",    32'(bus.int_re),    32'h0);
    chk("e1_stall", 32'(bus.cpu_stall), 32'h0);
    // misaligned read
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h0000_0002;
    #1;
    chk("e2_err",   32'(bus.bus_err),   32'h1);
    chk("e2_re",    32'(bus.int_re),    32'h0);
    chk("e2_done",  32'(bus.cpu_done),  32'h0);
    @(negedge clk); bus.cpu_rd = 1'b0;
    #1;
    chk("e2_idle",  32'(bus.bus_err),   32'h0);

    // asynchronous reset while ext_req is high
    @(negedge clk);
    bus.cpu_cs = 1'b0; bus.cpu_addr = 32'h0000_4000; bus.cpu_rd = 1'b1;
    @(negedge clk); #1;
    chk("rs_req1",  32'(bus.ext_req),   32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rs_req",   32'(bus.ext_req),   32'h0);
    chk("rs_stall", 32'(bus.cpu_stall), 32'h0);
    chk("rs_eaddr", bus.ext_addr,       32'h0);
    chk("rs_rdata", bus.cpu_rdata,      32'h0);
    bus.cpu_rd = 1'b0;
    @(negedge clk); rst = 1'b0;

    // recovery from IDLE
    @(negedge clk);
    bus.cpu_cs = 1'b1; bus.cpu_addr = 32'h0000_0008; bus.cpu_wr = 1'b1; bus.cpu_wdata = 32'hA5A5_A5A5;
    #1;
    chk("rc_done",  32'(bus.cpu_done),  32'h1);
    chk("rc_addr",  32'(bus.int_addr),  32'h2);
    @(negedge clk); bus.cpu_wr = 1'b0;
    chk("sb_empty", 32'(sb_q.size()),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
